logic_unit_scheduler: RTL and testbench
=======================================

# logic_unit_scheduler

Round-robin scheduler that shares one registered two-input logic unit among NREQ requesters. Each cycle it grants at most one requester, evaluates `f2 = a | b` and `f1 = stored_f2 & b` in one pass, and returns the result with the winning requester's ID through a one-entry response register. `stored_f2` is the f2 history kept from the previous grant. The block sits between several operand producers and a single downstream consumer.

## Interface
- NREQ, 4, number of requesters (2..16)
- WIDTH, 1, operand/result bit width
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous, active-high
- req_valid  in  NREQ  per-requester operand valid
- req_a  in  NREQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand b, same packing as req_a
- req_ready  out  NREQ  one-hot accept; bit i high means requester i is consumed this cycle
- rsp_valid  out  1  response register holds a result
- rsp_id  out  $clog2(NREQ)  index of the granted requester
- rsp_f1  out  WIDTH  stored_f2 & b
- rsp_f2  out  WIDTH  a | b
- rsp_ready  in  1  consumer accepts the response

## Operation
- FSM states:
  - EMPTY: no result held.
  - FULL: result held until consumed.
- Transitions:
  - EMPTY→FULL on any accept.
  - FULL→EMPTY when rsp_ready=1 and there is no accept that cycle.
  - FULL→FULL when rsp_ready=1 and there is an accept (refill), or when rsp_ready=0 (hold).
- Accept is allowed when state is EMPTY, or when state is FULL and rsp_ready=1.
- When accept is allowed and at least one req_valid bit is set:
  - Grant the first valid requester found searching upward from `ptr`, wrapping from NREQ-1 to 0.
  - Assert req_ready for that requester only. req_ready is combinational from state, rsp_ready and req_valid.
- On accept:
  - rsp_f2 ← a | b.
  - rsp_f1 ← stored_f2 & b, using the history value from before this accept.
  - stored_f2 ← a | b.
  - rsp_id ← grant index.
  - ptr ← grant index + 1, wrapping to 0.
- Without an accept, `ptr` and the history are unchanged.
- Bitwise arithmetic only; no carries; all results are WIDTH bits.
- Reset values:
  - state = EMPTY, rsp_valid = 0.
  - rsp_id, rsp_f1, rsp_f2 = 0.
  - ptr = 0 (requester 0 has first priority).
  - All history registers = 0.
  - req_ready = 0 while rst is high.
- Reset asserted mid-operation drops the held response and clears history; no partial result is ever presented.

## Timing
- Latency: accept at edge N, response visible after edge N with rsp_valid=1.
- Throughput: one result per cycle while rsp_ready stays high.
- While rsp_valid=1 and rsp_ready=0: rsp_id, rsp_f1 and rsp_f2 are held stable, and req_ready = 0.
- Requester handshake: the requester holds req_a and req_b stable while req_valid is high and its req_ready bit is low.
- No requests: no accept, and rsp_valid falls after the pending response is consumed.
- Simultaneous consume and accept in FULL: the new result replaces the old one at the same edge, with no bubble.

## Configuration
- Macro: `LOGIC_SCHED_HISTORY_PER_REQ_EN`.
- Defined: NREQ separate stored_f2 registers. Only the granted requester's entry is read and updated, so f1 depends only on that requester's own previous f2.
- Undefined: a single shared stored_f2, updated by every accept regardless of requester.

## Structure
- Package `logic_sched_pkg` contains:
  - the FSM state enum (ST_EMPTY, ST_FULL);
  - the default NREQ and WIDTH constants;
  - the ID-width localparam.
- Sub-module `rr_arbiter`:
  - Inputs: NREQ request vector, `ptr`, `enable`.
  - Outputs: one-hot grant, encoded grant index, `any`.
  - Purely combinational.
  - The top level owns `ptr`, the FSM and the datapath.

## Test plan
- Reset, then req_valid=0001 with a=0, b=1, rsp_ready=1 → accept in cycle 1; response rsp_id=0, f2=1, f1=0. A second identical request gives f1=1, f2=1.
- All four req_valid high continuously, rsp_ready=1 → grant order 0,1,2,3,0; rsp_valid stays 1 every cycle after the first.
- Response FULL with rsp_ready=0 for 3 cycles → req_ready=0000 and outputs stable. Raise rsp_ready → old response consumed and next request accepted on the same edge.
- Req0 with a=1, b=0 (f2=1), then req1 with a=0, b=1:
  - macro defined → req1 gets f1=0;
  - macro undefined → req1 gets f1=1.
- Assert rst for one cycle while FULL with rsp_ready=0 → after that edge rsp_valid=0, ptr=0 and history 0. The next req0 with b=1 gives f1=0.
- Only req3 valid after a grant to 1 → req3 granted, then ptr=0. Next, req0 and req2 both valid → req0 granted.

Source files
------------

// File: rtl/logic_sched_pkg.sv
// Shared types and defaults for the round-robin logic-unit scheduler.
package logic_sched_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } sched_state_e;

    localparam int unsigned DEFAULT_NREQ  = 4;
    localparam int unsigned DEFAULT_WIDTH = 1;
    localparam int unsigned DEFAULT_ID_W  = $clog2(DEFAULT_NREQ);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above i_ptr, wrapping.
module rr_arbiter
    import logic_sched_pkg::*;
#(
    parameter int unsigned NREQ = DEFAULT_NREQ,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    input  logic            i_enable,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    logic [ID_W:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Candidate index ptr+k, folded back into 0..NREQ-1.
            w_pos = {1'b0, i_ptr} + (ID_W + 1)'(k);
            if (w_pos >= (ID_W + 1)'(NREQ)) begin
                w_pos = w_pos - (ID_W + 1)'(NREQ);
            end
            if (i_enable && !o_any && i_req[w_pos[ID_W-1:0]]) begin
                o_any                   = 1'b1;
                o_grant[w_pos[ID_W-1:0]] = 1'b1;
                o_idx                   = w_pos[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/logic_unit_scheduler.sv
// Shares one registered (f2 = a|b, f1 = stored_f2 & b) unit among NREQ requesters.
// LOGIC_SCHED_HISTORY_PER_REQ_EN: keep one stored_f2 per requester instead of a shared one.
module logic_unit_scheduler
    import logic_sched_pkg::*;
#(
    parameter int unsigned NREQ  = DEFAULT_NREQ,
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned ID_W  = $clog2(NREQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*WIDTH-1:0] i_req_a,
    input  logic [NREQ*WIDTH-1:0] i_req_b,
    output logic [NREQ-1:0]       o_req_ready,
    output logic                  o_rsp_valid,
    output logic [ID_W-1:0]       o_rsp_id,
    output logic [WIDTH-1:0]      o_rsp_f1,
    output logic [WIDTH-1:0]      o_rsp_f2,
    input  logic                  i_rsp_ready
);

    sched_state_e    r_state;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_rsp_id;
    logic [WIDTH-1:0] r_rsp_f1;
    logic [WIDTH-1:0] r_rsp_f2;

    logic            w_enable;
    logic            w_accept;
    logic [NREQ-1:0] w_grant;
    logic [ID_W-1:0] w_idx;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_f2;
    logic [WIDTH-1:0] w_hist;
    logic [ID_W-1:0] w_ptr_next;

    // No grants during reset so nothing is consumed that the reset would discard.
    assign w_enable = !i_rst && ((r_state == ST_EMPTY) || i_rsp_ready);

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .i_req    (i_req_valid),
        .i_ptr    (r_ptr),
        .i_enable (w_enable),
        .o_grant  (w_grant),
        .o_idx    (w_idx),
        .o_any    (w_accept)
    );

    assign o_req_ready = w_grant;
    assign w_a         = i_req_a[w_idx*WIDTH +: WIDTH];
    assign w_b         = i_req_b[w_idx*WIDTH +: WIDTH];
    assign w_f2        = w_a | w_b;
    assign w_ptr_next  = (w_idx == ID_W'(NREQ - 1)) ? '0 : w_idx + ID_W'(1);

`ifdef LOGIC_SCHED_HISTORY_PER_REQ_EN
    logic [WIDTH-1:0] r_hist [NREQ];

    assign w_hist = r_hist[w_idx];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_hist[i] <= '0;
            end
        end else if (w_accept) begin
            r_hist[w_idx] <= w_f2;
        end
    end
`else
    logic [WIDTH-1:0] r_hist;

    assign w_hist = r_hist;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist <= '0;
        end else if (w_accept) begin
            r_hist <= w_f2;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_EMPTY;
            r_ptr    <= '0;
            r_rsp_id <= '0;
            r_rsp_f1 <= '0;
            r_rsp_f2 <= '0;
        end else begin
            if (w_accept) begin
                r_state  <= ST_FULL;
                r_ptr    <= w_ptr_next;
                r_rsp_id <= w_idx;
                r_rsp_f1 <= w_hist & w_b;
                r_rsp_f2 <= w_f2;
            end else if ((r_state == ST_FULL) && i_rsp_ready) begin
                r_state <= ST_EMPTY;
            end
        end
    end

    assign o_rsp_valid = (r_state == ST_FULL);
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_f1    = r_rsp_f1;
    assign o_rsp_f2    = r_rsp_f2;

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Directed self-checking bench for logic_unit_scheduler (NREQ=4, WIDTH=1).
module tb_logic_unit_scheduler;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 1;
    localparam int unsigned ID_W  = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [WIDTH-1:0]      rsp_f1;
    logic [WIDTH-1:0]      rsp_f2;
    logic                  rsp_ready;

    int n_tests;
    int n_fail;

    logic [ID_W-1:0] exp_order [5];
    logic [WIDTH-1:0] exp_f1_shared;

    logic_unit_scheduler #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_f1    (rsp_f1),
        .o_rsp_f2    (rsp_f2),
        .i_rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [ID_W-1:0] id,
                             input logic [WIDTH-1:0] f1, input logic [WIDTH-1:0] f2);
        check_eq({tag, ".valid"}, 32'(rsp_valid), 32'(v));
        check_eq({tag, ".id"}, 32'(rsp_id), 32'(id));
        check_eq({tag, ".f1"}, 32'(rsp_f1), 32'(f1));
        check_eq({tag, ".f2"}, 32'(rsp_f2), 32'(f2));
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        exp_order[0] = 2'd0;
        exp_order[1] = 2'd1;
        exp_order[2] = 2'd2;
        exp_order[3] = 2'd3;
        exp_order[4] = 2'd0;

        // Reset state; requests must be ignored while rst is high.
        tick();
        tick();
        check_eq("rst.req_ready", 32'(req_ready), 32'h0);
        check_rsp("rst", 1'b0, 2'd0, 1'b0, 1'b0);
        rst       = 1'b0;
        req_valid = '0;
        tick();
        check_eq("idle.valid", 32'(rsp_valid), 32'h0);

        // Basic function and shared-history f1.
        req_valid = 4'b0001;
        req_a     = 4'b0000;
        req_b     = 4'b0001;
        #1;
        check_eq("t1.req_ready", 32'(req_ready), 32'h1);
        tick();
        check_rsp("t1a", 1'b1, 2'd0, 1'b0, 1'b1);
        tick();
        check_rsp("t1b", 1'b1, 2'd0, 1'b1, 1'b1);
        req_valid = '0;
        tick();
        check_eq("t1.drain", 32'(rsp_valid), 32'h0);

        // Round-robin order from a fresh reset with all requesters valid.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("rr%0d.ready", i), 32'(req_ready), 32'(4'b0001 << exp_order[i]));
            tick();
            check_eq($sformatf("rr%0d.valid", i), 32'(rsp_valid), 32'h1);
            check_eq($sformatf("rr%0d.id", i), 32'(rsp_id), 32'(exp_order[i]));
        end

        // Backpressure: outputs frozen, no grants, then consume+refill on one edge.
        rsp_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("hold%0d.ready", i), 32'(req_ready), 32'h0);
            tick();
            check_rsp($sformatf("hold%0d", i), 1'b1, 2'd0, 1'b0, 1'b0);
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("refill.ready", 32'(req_ready), 32'h2);
        tick();
        check_rsp("refill", 1'b1, 2'd1, 1'b0, 1'b0);
        req_valid = '0;
        tick();
        check_eq("refill.drain", 32'(rsp_valid), 32'h0);

        // History selection: req0 leaves f2=1, then req1 with b=1.
        req_valid = 4'b0001;
        req_a     = 4'b0001;
        req_b     = 4'b0000;
        tick();
        check_rsp("hist0", 1'b1, 2'd0, 1'b0, 1'b1);
        req_valid = 4'b0010;
        req_a     = 4'b0000;
        req_b     = 4'b0010;
`ifdef LOGIC_SCHED_HISTORY_PER_REQ_EN
        exp_f1_shared = 1'b0;
`else
        exp_f1_shared = 1'b1;
`endif
        tick();
        check_rsp("hist1", 1'b1, 2'd1, exp_f1_shared, 1'b1);
        req_valid = '0;
        tick();

        // Mid-operation reset while FULL and stalled.
        req_valid = 4'b0001;
        req_a     = 4'b0000;
        req_b     = 4'b0001;
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        check_rsp("prerst", 1'b1, 2'd0, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_rsp("midrst", 1'b0, 2'd0, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        req_a     = 4'b0000;
        req_b     = 4'b1111;
        #1;
        check_eq("midrst.ready", 32'(req_ready), 32'h1);
        tick();
        check_rsp("postrst", 1'b1, 2'd0, 1'b0, 1'b1);
        req_valid = '0;
        tick();

        // Pointer wrap: grant 1, then lone req3, then req0 beats req2.
        req_b     = '0;
        req_valid = 4'b0010;
        tick();
        check_eq("wrap.id1", 32'(rsp_id), 32'h1);
        req_valid = 4'b1000;
        #1;
        check_eq("wrap.ready3", 32'(req_ready), 32'h8);
        tick();
        check_eq("wrap.id3", 32'(rsp_id), 32'h3);
        req_valid = 4'b0101;
        #1;
        check_eq("wrap.ready0", 32'(req_ready), 32'h1);
        tick();
        check_eq("wrap.id0", 32'(rsp_id), 32'h0);
        req_valid = '0;
        tick();
        check_eq("end.valid", 32'(rsp_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
